comparador_multi: RTL and testbench
===================================

Name: comparador_multi

Overview:
- Parametrised successor of the single-channel hash/target comparator in the hash-generator datapath.
- Accepts candidate hashes and nonces from NUM_CH hash cores and checks the top CMP_BYTES bytes of each hash against the 8-bit target.
- Arbitrates the winning results round-robin into a result FIFO, read out through a valid/ready handshake.
- Unlike the single-channel comparator, it queues every winner instead of keeping only the last one, and flags any result it loses.

Parameters:
- NUM_CH, 2, number of hash-core input channels (1..8).
- H_W, 24, hash width in bits; a multiple of 8.
- NONCE_W, 32, nonce width in bits.
- CMP_BYTES, 2, number of most-significant hash bytes compared against target (1..H_W/8).
- DEPTH, 4, result FIFO depth; a power of 2, at least 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel strobe: hash and nonce are valid this cycle.
- in_H  in  NUM_CH*H_W  packed hashes; channel i occupies [i*H_W +: H_W].
- in_nonce  in  NUM_CH*NONCE_W  packed nonces; channel i occupies [i*NONCE_W +: NONCE_W].
- target  in  8  byte threshold.
- fin  in  1  search finished; blocks new inputs.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts the head.
- out_nonce  out  NONCE_W  winning nonce at the FIFO head.
- out_bounty  out  H_W  full hash at the FIFO head.
- out_ch  out  max(1,$clog2(NUM_CH))  source channel of the FIFO head.
- fifo_full  out  1  FIFO occupancy equals DEPTH.
- drop  out  1  sticky: a pending result was overwritten.
- match_cnt  out  16  saturating count of results written into the FIFO.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - FIFO pointers and count are 0.
  - All pending slots are cleared.
  - Round-robin pointer is 0.
- Hit rule, channel i:
  - hit_i = in_valid[i] && !fin && every byte k of the top CMP_BYTES bytes of in_H[i] is < target (unsigned, strict).
  - target = 0 never produces a hit.
- Stage 1, pending slot per channel:
  - On hit_i, the slot loads {nonce, H} and its pend flag sets at the next edge.
  - If the slot is already pending and is not granted in that same cycle, the new hit overwrites it (newest kept) and drop sets. drop clears only on reset.
  - If the slot is granted in the same cycle, the new hit loads cleanly with no drop.
- Arbiter:
  - Grants one pending channel per cycle, when count < DEPTH or a pop occurs in the same cycle.
  - Search order starts at the rr pointer; after a grant, rr = grant+1 mod NUM_CH.
  - The granted slot's pend flag clears and {ch, nonce, H} is written to the FIFO tail.
- FIFO:
  - Show-ahead: out_* are driven from the head register and are stable while out_valid && !out_ready.
  - out_valid = (count != 0).
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Outputs are undefined content when out_valid = 0 (implementation holds the last values).
- Latency: a hit presented at cycle 0 with the FIFO empty and no contention gives out_valid = 1 in cycle 2 (after two edges).
- fin:
  - fin = 1 ignores all inputs.
  - Pending slots and the FIFO keep draining.
  - fin does not clear any state.
- match_cnt increments once per FIFO push and saturates at 0xFFFF.
- Reset mid-operation clears everything immediately, including queued results.

Optional Feature:
- Macro: COMPARADOR_MULTI_STATS_EN.
- When defined:
  - Adds output hash_cnt[31:0]: count of cycles × channels with in_valid && !fin, summing up to NUM_CH per cycle, wrapping modulo 2^32.
  - Adds output best_bounty[H_W-1:0]: the numerically smallest H ever pushed to the FIFO. It resets to all-ones and updates on push when H < best_bounty.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- NUM_CH=2, target=0x40, ch0 in_H=0x3F20AA, nonce=5, out_ready=1 -> out_valid in cycle 2 with out_nonce=5, out_bounty=0x3F20AA, out_ch=0, match_cnt=1.
- target=0x40, in_H=0x3F40FF (second byte equal) and in_H=0x41000 0 (first byte high) -> no push, out_valid stays 0, match_cnt=0.
- Both channels hit every cycle for 6 cycles, out_ready=0 -> FIFO fills to 4, fifo_full=1, drop=1; then out_ready=1 -> pops alternate ch0/ch1 order starting ch0.
- Hit on ch1 with fin=1 -> ignored; pending result from the previous cycle still reaches the FIFO and drains.
- Assert reset while FIFO holds 3 entries -> out_valid, fifo_full, drop, and match_cnt are 0 immediately; a post-release hit delivers after 2 cycles.
- With COMPARADOR_MULTI_STATS_EN: push H=0x100000 then H=0x0F0000 over 3 valid cycles on 2 channels -> best_bounty=0x0F0000, hash_cnt=6.

Source files
------------

// File: rtl/comparador_multi.sv
// comparador_multi: NUM_CH-channel hash/target comparator, round-robin arbiter and show-ahead result FIFO.
// Optional statistics outputs (hash_cnt, best_bounty) exist only when COMPARADOR_MULTI_STATS_EN is defined.
module comparador_multi #(
    parameter int NUM_CH    = 2,
    parameter int H_W       = 24,
    parameter int NONCE_W   = 32,
    parameter int CMP_BYTES = 2,
    parameter int DEPTH     = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH*H_W-1:0]     in_H,
    input  logic [NUM_CH*NONCE_W-1:0] in_nonce,
    input  logic [7:0]                target,
    input  logic                      fin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NONCE_W-1:0]        out_nonce,
    output logic [H_W-1:0]            out_bounty,
    output logic [CH_W-1:0]           out_ch,
    output logic                      fifo_full,
    output logic                      drop,
`ifdef COMPARADOR_MULTI_STATS_EN
    output logic [31:0]               hash_cnt,
    output logic [H_W-1:0]            best_bounty,
`endif
    output logic [15:0]               match_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    NUM_CH_C = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0]  hit_s;
    logic [NUM_CH-1:0]  rot_s;
    logic [NUM_CH-1:0]  gnt_vec_s;
    logic [NUM_CH-1:0]  pend_q, pend_d;
    logic [NONCE_W-1:0] slot_nonce_q [NUM_CH];
    logic [H_W-1:0]     slot_h_q     [NUM_CH];

    logic               pop_s, push_ok_s, push_s;
    logic [CH_W:0]      sum_s;
    logic [CH_W-1:0]    cand_s, gnt_idx_s;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic               drop_q, drop_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        match_cnt_q, match_cnt_d;

    logic [CH_W-1:0]    mem_ch_q    [DEPTH];
    logic [NONCE_W-1:0] mem_nonce_q [DEPTH];
    logic [H_W-1:0]     mem_h_q     [DEPTH];

    // Hit detection: every compared top byte must be strictly below target.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hit_s[i] = in_valid[i] & ~fin;
            for (int k = 0; k < CMP_BYTES; k++) begin
                hit_s[i] = hit_s[i] & (in_H[i*H_W + H_W - 8*(k+1) +: 8] < target);
            end
        end
    end

    // Round-robin arbiter: rotate pending flags so bit 0 is the rr channel, lowest set bit wins.
    always_comb begin
        pop_s     = (count_q != {CNT_W{1'b0}}) & out_ready;
        push_ok_s = (count_q < DEPTH_C) | pop_s;
        rot_s     = NUM_CH'({pend_q, pend_q} >> rr_q);
        gnt_idx_s = {CH_W{1'b0}};
        sum_s     = {(CH_W+1){1'b0}};
        cand_s    = {CH_W{1'b0}};
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum_s     = {1'b0, rr_q} + (CH_W + 1)'(k);
            cand_s    = (sum_s >= NUM_CH_C) ? CH_W'(sum_s - NUM_CH_C) : sum_s[CH_W-1:0];
            gnt_idx_s = rot_s[k] ? cand_s : gnt_idx_s;
        end
        push_s = push_ok_s & (|pend_q);
        for (int i = 0; i < NUM_CH; i++) begin
            gnt_vec_s[i] = push_s & (gnt_idx_s == CH_W'(i));
        end
    end

    // Next-state for pending flags, drop, rr pointer, FIFO pointers and counters.
    always_comb begin
        pend_d = (pend_q & ~gnt_vec_s) | hit_s;
        drop_d = drop_q | (|(hit_s & pend_q & ~gnt_vec_s));
        if (push_s) begin
            rr_d = (gnt_idx_s == LAST_CH) ? {CH_W{1'b0}} : gnt_idx_s + CH_W'(1);
        end else begin
            rr_d = rr_q;
        end
        wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        match_cnt_d = (push_s && (match_cnt_q != 16'hFFFF)) ? match_cnt_q + 16'd1 : match_cnt_q;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q      <= {NUM_CH{1'b0}};
            drop_q      <= 1'b0;
            rr_q        <= {CH_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            match_cnt_q <= 16'd0;
        end else begin
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // Per-channel pending slot payload; a new hit always replaces the old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                slot_nonce_q[i] <= {NONCE_W{1'b0}};
                slot_h_q[i]     <= {H_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit_s[i]) begin
                    slot_nonce_q[i] <= in_nonce[i*NONCE_W +: NONCE_W];
                    slot_h_q[i]     <= in_H[i*H_W +: H_W];
                end
            end
        end
    end

    // FIFO storage; cleared on reset so every output reads 0 afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_ch_q[j]    <= {CH_W{1'b0}};
                mem_nonce_q[j] <= {NONCE_W{1'b0}};
                mem_h_q[j]     <= {H_W{1'b0}};
            end
        end else if (push_s) begin
            mem_ch_q[wr_ptr_q]    <= gnt_idx_s;
            mem_nonce_q[wr_ptr_q] <= slot_nonce_q[gnt_idx_s];
            mem_h_q[wr_ptr_q]     <= slot_h_q[gnt_idx_s];
        end
    end

    assign out_valid  = (count_q != {CNT_W{1'b0}});
    assign fifo_full  = (count_q == DEPTH_C);
    assign out_nonce  = mem_nonce_q[rd_ptr_q];
    assign out_bounty = mem_h_q[rd_ptr_q];
    assign out_ch     = mem_ch_q[rd_ptr_q];
    assign drop       = drop_q;
    assign match_cnt  = match_cnt_q;

`ifdef COMPARADOR_MULTI_STATS_EN
    logic [31:0]    hash_cnt_q, hash_cnt_d;
    logic [H_W-1:0] best_q, best_d;

    // Statistics next-state: valid hash attempts and smallest pushed hash.
    always_comb begin
        hash_cnt_d = hash_cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            hash_cnt_d = hash_cnt_d + {31'd0, in_valid[i] & ~fin};
        end
        if (push_s && (slot_h_q[gnt_idx_s] < best_q)) begin
            best_d = slot_h_q[gnt_idx_s];
        end else begin
            best_d = best_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hash_cnt_q <= 32'd0;
            best_q     <= {H_W{1'b1}};
        end else begin
            hash_cnt_q <= hash_cnt_d;
            best_q     <= best_d;
        end
    end

    assign hash_cnt    = hash_cnt_q;
    assign best_bounty = best_q;
`endif

endmodule

// File: tb/tb_comparador_multi.sv
// Self-checking bench for comparador_multi: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_comparador_multi;
    localparam int NUM_CH    = 2;
    localparam int H_W       = 24;
    localparam int NONCE_W   = 32;
    localparam int CMP_BYTES = 2;
    localparam int DEPTH     = 4;
    localparam int CH_W      = 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_CH-1:0]         in_valid = '0;
    logic [NUM_CH*H_W-1:0]     in_H = '0;
    logic [NUM_CH*NONCE_W-1:0] in_nonce = '0;
    logic [7:0]                target = 8'h40;
    logic                      fin = 1'b0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [NONCE_W-1:0]        out_nonce;
    logic [H_W-1:0]            out_bounty;
    logic [CH_W-1:0]           out_ch;
    logic                      fifo_full;
    logic                      drop;
    logic [15:0]               match_cnt;
`ifdef COMPARADOR_MULTI_STATS_EN
    logic [31:0]               hash_cnt;
    logic [H_W-1:0]            best_bounty;
`endif

    comparador_multi #(
        .NUM_CH(NUM_CH), .H_W(H_W), .NONCE_W(NONCE_W), .CMP_BYTES(CMP_BYTES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_H(in_H), .in_nonce(in_nonce),
        .target(target), .fin(fin), .out_valid(out_valid), .out_ready(out_ready),
        .out_nonce(out_nonce), .out_bounty(out_bounty), .out_ch(out_ch),
        .fifo_full(fifo_full), .drop(drop),
`ifdef COMPARADOR_MULTI_STATS_EN
        .hash_cnt(hash_cnt), .best_bounty(best_bounty),
`endif
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 ch;
        logic [NONCE_W-1:0] nonce;
        logic [H_W-1:0]     h;
    } ent_t;

    ent_t               mq[$];
    ent_t               m_e;
    bit                 mpend[NUM_CH];
    logic [NONCE_W-1:0] mpn[NUM_CH];
    logic [H_W-1:0]     mph[NUM_CH];
    int                 mrr = 0;
    bit                 mdrop = 1'b0;
    int                 mcnt = 0;
    logic [31:0]        mhash = 32'd0;
    logic [H_W-1:0]     mbest = '1;
    bit                 m_pop;
    int                 m_g;
    int                 m_c;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [H_W-1:0] h, input logic [7:0] t);
        logic [7:0] b;
        for (int k = 0; k < CMP_BYTES; k++) begin
            b = 8'(h >> (H_W - 8 * (k + 1)));
            if (b >= t) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: a queue FIFO, pending slots and a round-robin search from rr.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            for (int c = 0; c < NUM_CH; c++) mpend[c] = 1'b0;
            mrr = 0; mdrop = 1'b0; mcnt = 0; mhash = 32'd0; mbest = '1;
        end else begin
            m_pop = (mq.size() != 0) && out_ready;
            m_g = -1;
            if ((mq.size() < DEPTH) || m_pop) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    m_c = (mrr + k) % NUM_CH;
                    if (m_g < 0 && mpend[m_c]) m_g = m_c;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_g >= 0) begin
                m_e.ch = m_g; m_e.nonce = mpn[m_g]; m_e.h = mph[m_g];
                mq.push_back(m_e);
                mpend[m_g] = 1'b0;
                mrr = (m_g + 1) % NUM_CH;
                if (mcnt < 65535) mcnt++;
                if (m_e.h < mbest) mbest = m_e.h;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!fin && in_valid[c]) begin
                    mhash = mhash + 32'd1;
                    if (model_hit(in_H[c*H_W +: H_W], target)) begin
                        if (mpend[c]) mdrop = 1'b1;
                        mpend[c] = 1'b1;
                        mpn[c] = in_nonce[c*NONCE_W +: NONCE_W];
                        mph[c] = in_H[c*H_W +: H_W];
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", out_valid, mq.size() != 0);
            chk("fifo_full", fifo_full, mq.size() == DEPTH);
            chk("drop", drop, mdrop);
            chk("match_cnt", match_cnt, mcnt);
            if (mq.size() != 0) begin
                chk("out_nonce", out_nonce, mq[0].nonce);
                chk("out_bounty", out_bounty, mq[0].h);
                chk("out_ch", out_ch, mq[0].ch);
            end
`ifdef COMPARADOR_MULTI_STATS_EN
            chk("hash_cnt", hash_cnt, mhash);
            chk("best_bounty", best_bounty, mbest);
`endif
        end
    end

    task automatic drive(input logic [1:0] v, input logic [H_W-1:0] h0, input logic [H_W-1:0] h1,
                         input logic [NONCE_W-1:0] n0, input logic [NONCE_W-1:0] n1);
        in_valid = v;
        in_H     = {h1, h0};
        in_nonce = {n1, n0};
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; fin = 1'b0; out_ready = 1'b0; target = 8'h40;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0]     tgt_tab [4] = '{8'h00, 8'h40, 8'h80, 8'hFF};
    logic [H_W-1:0] rh;

    initial begin
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_match_cnt", match_cnt, 16'd0);
        chk("rst_out_nonce", out_nonce, 32'd0);

        // Single hit on ch0: visible after two edges.
        out_ready = 1'b1;
        drive(2'b01, 24'h3F20AA, 24'h0, 32'd5, 32'd0);
        @(negedge clk);
        drive(2'b00, 24'h0, 24'h0, 32'd0, 32'd0);
        chk("lat1_out_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_nonce", out_nonce, 32'd5);
        chk("t1_out_bounty", out_bounty, 24'h3F20AA);
        chk("t1_out_ch", out_ch, 1'b0);
        chk("t1_match_cnt", match_cnt, 16'd1);

        // Equal byte and high first byte: no hit.
        do_reset();
        drive(2'b11, 24'h3F40FF, 24'h410000, 32'd1, 32'd2);
        repeat (3) @(negedge clk);
        drive(2'b00, 24'h0, 24'h0, 32'd0, 32'd0);
        chk("t2_out_valid", out_valid, 1'b0);
        chk("t2_match_cnt", match_cnt, 16'd0);

        // Both channels hit six cycles with the consumer stalled.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 24'h3F20AA, 24'h1010AA, 32'(i * 16), 32'(i * 16 + 1));
            @(negedge clk);
        end
        drive(2'b00, 24'h0, 24'h0, 32'd0, 32'd0);
        chk("t3_fifo_full", fifo_full, 1'b1);
        chk("t3_drop", drop, 1'b1);
        chk("t3_match_cnt", match_cnt, 16'd4);
        chk("t3_head_ch", out_ch, 1'b0);
        chk("t3_head_nonce", out_nonce, 32'h00);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_pop1_ch", out_ch, 1'b1);
        chk("t3_pop1_nonce", out_nonce, 32'h11);
        repeat (8) @(negedge clk);
        chk("t3_drained", out_valid, 1'b0);
        chk("t3_match_total", match_cnt, 16'd6);

        // fin blocks the new ch1 hit while the pending ch0 result drains.
        do_reset();
        out_ready = 1'b1;
        drive(2'b01, 24'h101010, 24'h0, 32'd7, 32'd0);
        @(negedge clk);
        fin = 1'b1;
        drive(2'b10, 24'h0, 24'h101010, 32'd0, 32'd9);
        @(negedge clk);
        chk("t4_out_valid", out_valid, 1'b1);
        chk("t4_out_nonce", out_nonce, 32'd7);
        repeat (3) @(negedge clk);
        chk("t4_drained", out_valid, 1'b0);
        chk("t4_match_cnt", match_cnt, 16'd1);
        fin = 1'b0;
        drive(2'b00, 24'h0, 24'h0, 32'd0, 32'd0);

        // Reset with three queued entries clears everything at once.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(2'b01, 24'h0000AA, 24'h0, 32'(i), 32'd0);
            @(negedge clk);
        end
        drive(2'b00, 24'h0, 24'h0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t5_match_cnt", match_cnt, 16'd3);
        chk("t5_head_nonce", out_nonce, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid, 1'b0);
        chk("t5_rst_fifo_full", fifo_full, 1'b0);
        chk("t5_rst_drop", drop, 1'b0);
        chk("t5_rst_match_cnt", match_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        drive(2'b01, 24'h0000AB, 24'h0, 32'hAB, 32'd0);
        @(negedge clk);
        drive(2'b00, 24'h0, 24'h0, 32'd0, 32'd0);
        chk("t5_lat1", out_valid, 1'b0);
        @(negedge clk);
        chk("t5_lat2", out_valid, 1'b1);
        chk("t5_nonce", out_nonce, 32'hAB);

`ifdef COMPARADOR_MULTI_STATS_EN
        // Statistics: six valid attempts, smallest pushed hash kept.
        do_reset();
        out_ready = 1'b1;
        drive(2'b11, 24'h100000, 24'hFF0000, 32'd1, 32'd2);
        @(negedge clk);
        drive(2'b11, 24'h0F0000, 24'hFF0000, 32'd3, 32'd4);
        @(negedge clk);
        drive(2'b11, 24'hFF0000, 24'hFF0000, 32'd5, 32'd6);
        @(negedge clk);
        drive(2'b00, 24'h0, 24'h0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        chk("st_hash_cnt", hash_cnt, 32'd6);
        chk("st_best", best_bounty, 24'h0F0000);
`endif

        // Randomized traffic, checked every cycle by the model comparison.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 100 == 0) target = tgt_tab[$urandom_range(0, 3)];
            fin       = ($urandom_range(0, 9) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            reset     = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                rh = H_W'($urandom);
                if ($urandom_range(0, 2) != 0) rh = rh & 24'h3F3FFF;
                in_valid[c] = $urandom_range(0, 3) != 0;
                in_H[c*H_W +: H_W] = rh;
                in_nonce[c*NONCE_W +: NONCE_W] = $urandom;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("final_drained", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
